mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-style control FSM: fetch/decode/execute sequencing, sticky
// illegal-opcode flag and a retired-instruction counter.
module mc_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ir_wr,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_wr,
  output logic [3:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    StIf    = 4'd0,
    StId    = 4'd1,
    StMaddr = 4'd2,
    StMrd   = 4'd3,
    StMwb   = 4'd4,
    StMwr   = 4'd5,
    StRex   = 4'd6,
    StRwb   = 4'd7,
    StBr    = 4'd8,
    StJmp   = 4'd9,
    StIex   = 4'd10,
    StIwb   = 4'd11,
    StIll   = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  state_e             state_q, state_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIf;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = 2'd0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_wr     = 1'b0;
    case (state_q)
      StIf: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'd1;
        // PC+4 and IR load commit only in the cycle memory delivers the word.
        ir_wr     = mem_ready;
        pc_wr     = mem_ready;
        if (mem_ready) state_d = StId;
      end
      StId: begin
        alu_src_b = 2'd3;
        case (opcode)
          OpRtype:     state_d = StRex;
          OpLw, OpSw:  state_d = StMaddr;
          OpBeq, OpBne: state_d = StBr;
          OpJ:         state_d = StJmp;
          OpAddi:      state_d = StIex;
          default:     state_d = StIll;
        endcase
      end
      StMaddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (opcode == OpSw) ? StMwr : StMrd;
      end
      StMrd: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
        if (mem_ready) state_d = StMwb;
      end
      StMwb: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StIf;
        retire     = 1'b1;
      end
      StMwr: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
        if (mem_ready) begin
          state_d = StIf;
          retire  = 1'b1;
        end
      end
      StRex: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        state_d   = StRwb;
      end
      StRwb: begin
        reg_wr  = 1'b1;
        reg_dst = 1'b1;
        state_d = StIf;
        retire  = 1'b1;
      end
      StIex: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = StIwb;
      end
      StIwb: begin
        reg_wr  = 1'b1;
        state_d = StIf;
        retire  = 1'b1;
      end
      StBr: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd1;
        pc_src    = 2'd1;
        pc_wr     = (opcode == OpBne) ? ~zero : zero;
        state_d   = StIf;
        retire    = 1'b1;
      end
      StJmp: begin
        pc_src  = 2'd2;
        pc_wr   = 1'b1;
        state_d = StIf;
        retire  = 1'b1;
      end
      StIll:   state_d = StIll;
      default: state_d = StIll;
    endcase
  end

  assign err_d     = err_q | (state_d == StIll);
  assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};

  assign state   = state_q;
  assign err     = err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: instruction-plan reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mc_ctrl;
  localparam int CW = 32;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] JO = 6'b000010, ADDI = 6'b001000, RT = 6'b000000, BAD = 6'b111111;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] opcode = LW;
  logic zero = 1'b0, mem_ready = 1'b1;
  logic pc_wr, iord, mem_rd, mem_wr, ir_wr, alu_src_a, reg_dst, mem_to_reg, reg_wr, err;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state;
  logic [CW-1:0] retired;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_wr(pc_wr), .pc_src(pc_src), .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ir_wr(ir_wr), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_wr(reg_wr), .state(state), .err(err),
    .retired(retired)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an instruction is an IF/ID prefix plus a plan of remaining steps.
  int            m_state = 0;
  int            plan[$];
  logic          m_bne = 1'b0;
  logic          m_err = 1'b0;
  logic [CW-1:0] m_ret = '0;

  // Control vector order: pc_wr,pc_src,iord,mem_rd,mem_wr,ir_wr,a,b,op,reg_dst,m2r,reg_wr
  function automatic logic [14:0] exp_ctrl(input int st, input logic mr, input logic z,
                                            input logic bne);
    logic pw, io, rd, wr, iw, a, rdst, m2r, rw;
    logic [1:0] ps, b, op;
    {pw, io, rd, wr, iw, a, rdst, m2r, rw} = '0;
    {ps, b, op} = '0;
    case (st)
      0:  begin rd = 1; b = 1; iw = mr; pw = mr; end
      1:  b = 3;
      2:  begin a = 1; b = 2; end
      3:  begin rd = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin wr = 1; io = 1; end
      6:  begin a = 1; op = 2; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin a = 1; op = 1; ps = 1; pw = bne ? ~z : z; end
      9:  begin ps = 2; pw = 1; end
      10: begin a = 1; b = 2; end
      11: rw = 1;
      default: ;
    endcase
    return {pw, ps, io, rd, wr, iw, a, b, op, rdst, m2r, rw};
  endfunction

  always @(negedge clk) begin : compare
    if (!rst_n) begin
      m_state = 0; plan.delete(); m_err = 1'b0; m_ret = '0;
    end
    chk("ctrl", 64'({pc_wr, pc_src, iord, mem_rd, mem_wr, ir_wr, alu_src_a, alu_src_b,
                     alu_op, reg_dst, mem_to_reg, reg_wr}),
        64'(exp_ctrl(m_state, mem_ready, zero, m_bne)));
    chk("state", 64'(state), 64'(m_state));
    chk("err", 64'(err), 64'(m_err));
    chk("retired", 64'(retired), 64'(m_ret));
    if (rst_n) begin
      if (m_state == 12) begin
      end else if (m_state == 0) begin
        if (mem_ready) m_state = 1;
      end else if (m_state == 1) begin
        case (opcode)
          RT:       plan = {6, 7};
          LW:       plan = {2, 3, 4};
          SW:       plan = {2, 5};
          BEQ:      begin plan = {8}; m_bne = 1'b0; end
          BNE:      begin plan = {8}; m_bne = 1'b1; end
          JO:       plan = {9};
          ADDI:     plan = {10, 11};
          default:  plan = {12};
        endcase
        m_state = plan.pop_front();
        if (m_state == 12) m_err = 1'b1;
      end else if ((m_state == 3 || m_state == 5) && !mem_ready) begin
      end else if (plan.size() > 0) begin
        m_state = plan.pop_front();
      end else begin
        m_state = 0;
        m_ret++;
      end
    end
  end

  task automatic step(input logic [5:0] op, input logic mr, input logic z);
    @(posedge clk); #1;
    opcode = op; mem_ready = mr; zero = z;
    @(negedge clk); #1;
  endtask

  // Caller drops rst_n; reset must span a falling edge before release.
  task automatic finish_reset();
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    @(negedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] tbl [7] = '{RT, LW, SW, BEQ, BNE, JO, ADDI};
    if ($urandom_range(0, 15) == 0) return 6'($urandom_range(0, 63));
    return tbl[$urandom_range(0, 6)];
  endfunction

  initial begin
    int lw_seq [5] = '{1, 2, 3, 4, 0};
    logic [5:0] op;
    int ill_cnt;

    // Power-on reset, then lw with mem_ready always high.
    rst_n = 1'b0;
    #2;
    finish_reset();
    opcode = LW; mem_ready = 1'b1; zero = 1'b0;
    @(negedge clk); #1;
    chk("first_fetch", 64'({state, ir_wr, pc_wr}), 64'({4'd0, 1'b1, 1'b1}));
    for (int i = 0; i < 5; i++) begin
      step(LW, 1'b1, 1'b0);
      chk("lw_state", 64'(state), 64'(lw_seq[i]));
      if (i == 3) chk("lw_wb", 64'({reg_wr, mem_to_reg}), 64'b11);
    end
    chk("lw_retired", 64'(retired), 64'd1);

    // sw with three stalled cycles in MWR.
    step(SW, 1'b1, 1'b0);
    step(SW, 1'b1, 1'b0);
    chk("sw_maddr", 64'(state), 64'd2);
    for (int i = 0; i < 4; i++) begin
      step(SW, (i == 3), 1'b0);
      chk("sw_hold", 64'({state, mem_wr, reg_wr}), 64'({4'd5, 1'b1, 1'b0}));
    end
    step(BEQ, 1'b1, 1'b1);
    chk("sw_retired", 64'({state, retired}), 64'({4'd0, 32'd2}));

    // beq then bne, both with zero=1.
    step(BEQ, 1'b1, 1'b1);
    step(BEQ, 1'b1, 1'b1);
    chk("beq_br", 64'({state, pc_wr, pc_src}), 64'({4'd8, 1'b1, 2'd1}));
    step(BNE, 1'b1, 1'b1);
    step(BNE, 1'b1, 1'b1);
    step(BNE, 1'b1, 1'b1);
    chk("bne_br", 64'({state, pc_wr, pc_src}), 64'({4'd8, 1'b0, 2'd1}));
    step(JO, 1'b1, 1'b0);
    chk("br_retired", 64'(retired), 64'd4);

    // Ten jumps back to back: 30 cycles.
    for (int i = 0; i < 10; i++) begin
      step(JO, 1'b1, 1'b0);
      step(JO, 1'b1, 1'b0);
      chk("jmp_out", 64'({state, pc_src, pc_wr}), 64'({4'd9, 2'd2, 1'b1}));
      step(JO, 1'b1, 1'b0);
    end
    chk("j_retired", 64'({state, retired}), 64'({4'd0, 32'd14}));

    // Illegal opcode locks up with all strobes low.
    step(BAD, 1'b1, 1'b0);
    step(BAD, 1'b1, 1'b0);
    chk("ill_enter", 64'({state, err}), 64'({4'd12, 1'b1}));
    for (int i = 0; i < 20; i++) begin
      step(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("ill_strobes", 64'({mem_rd, mem_wr, reg_wr, ir_wr, pc_wr, err, state}),
          64'({5'b0, 1'b1, 4'd12}));
    end
    rst_n = 1'b0;
    finish_reset();
    opcode = LW; mem_ready = 1'b1;
    @(negedge clk); #1;

    // Reset while waiting in MRD abandons the load.
    step(LW, 1'b1, 1'b0);
    step(LW, 1'b1, 1'b0);
    step(LW, 1'b0, 1'b0);
    step(LW, 1'b0, 1'b0);
    chk("mrd_wait", 64'(state), 64'd3);
    rst_n = 1'b0;
    finish_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(ADDI, 1'b0, 1'b0);
      chk("post_rst", 64'({state, reg_wr, retired}), 64'({4'd0, 1'b0, 32'd0}));
    end

    // Randomized traffic against the model.
    op = pick_op();
    ill_cnt = 0;
    for (int n = 0; n < 4000; n++) begin
      if (state == 4'd12) ill_cnt++;
      if (ill_cnt > 3 || $urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        finish_reset();
        ill_cnt = 0;
      end
      if (state == 4'd0) op = pick_op();
      step(op, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
